stack_sequencer: RTL and testbench

Multi-cycle sequencer for all stack traffic: PUSH, POP and interrupt entry.
- Reads operands and SP from the register file; owns the register-file write port while busy.
- Drives the data-memory bus through a req/ready handshake.
- Redirects PC/SR updates to load strobes, because PC and SR are read-only in the register file.
- Sits between the instruction decoder and the register file / memory interface.

---
 rtl/stack_pkg.sv | 42 ++++
 rtl/mem_port_handshake.sv | 51 +++++
 rtl/stack_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack sequencer: command opcodes, FSM states,
// register-file addresses of the special registers and the memory request payload.
package stack_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned REG_W  = 4;

  localparam logic [REG_W-1:0] REG_ISR = 4'hC;
  localparam logic [REG_W-1:0] REG_SP  = 4'hD;
  localparam logic [REG_W-1:0] REG_SR  = 4'hE;
  localparam logic [REG_W-1:0] REG_PC  = 4'hF;

  typedef enum logic [1:0] {
    PUSH      = 2'd0,
    POP       = 2'd1,
    INT_ENTER = 2'd2,
    NOP       = 2'd3
  } stack_op_t;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_WR,
    PUSH_SP,
    POP_RD,
    POP_WB,
    POP_SP,
    INT_PC,
    INT_SR,
    INT_SP,
    INT_JMP,
    NOP_DONE,
    FAULT
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_handshake.sv
// Data-memory request port: captures a command on start_c and holds req/we/addr/wdata
// stable until mem_ready completes it; a new request can only start once idle again.
module mem_port_handshake
  import stack_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start_c,
  input  mem_cmd_t          cmd_c,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              complete_c
);

  logic     req_q, req_d;
  mem_cmd_t cmd_q, cmd_d;

  // Request drops on the completing edge, so back-to-back requests are a cycle apart.
  always_comb begin
    req_d = req_q;
    cmd_d = cmd_q;
    if (req_q) begin
      if (mem_ready) req_d = 1'b0;
    end else if (start_c) begin
      req_d = 1'b1;
      cmd_d = cmd_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      req_q <= req_d;
      cmd_q <= cmd_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = cmd_q.we;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;
  assign busy       = req_q;
  assign complete_c = req_q & mem_ready;

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH / POP / interrupt-entry sequencer between decoder, register file and
// data memory. Optional stack bound checking at accept is enabled by STACK_LIMIT_EN.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] STACK_TOP    = 16'hBFFF,
  parameter logic [ADDR_W-1:0] STACK_BOTTOM = 16'h8000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [REG_W-1:0]  cmd_reg,
  output logic [REG_W-1:0]  rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic [DATA_W-1:0] sp,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] sr,
  input  logic [DATA_W-1:0] isr,
  output logic [REG_W-1:0]  rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              pc_load,
  output logic              sr_load,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              fault
);

  state_t            state_q, state_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] popped_q, popped_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic [REG_W-1:0]  rf_write_addr_q, rf_write_addr_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic              rf_write_en_q, rf_write_en_d;
  logic              pc_load_q, pc_load_d;
  logic              sr_load_q, sr_load_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic              hs_start_c;
  mem_cmd_t          hs_cmd_c;
  logic              hs_busy;
  logic              hs_complete_c;
  logic              limit_fault_c;

`ifdef STACK_LIMIT_EN
  // Bounds are judged on the SP sampled at accept.
  always_comb begin
    limit_fault_c = 1'b0;
    case (stack_op_t'(cmd_op))
      PUSH:      limit_fault_c = (sp < STACK_BOTTOM);
      INT_ENTER: limit_fault_c = (sp < ADDR_W'(STACK_BOTTOM + 16'd1));
      POP:       limit_fault_c = (sp >= STACK_TOP);
      default:   limit_fault_c = 1'b0;
    endcase
  end
`else
  assign limit_fault_c = 1'b0;
`endif

  // Tie-off for constants that are not referenced in every build.
  logic unused_c;
  assign unused_c = ^{REG_ISR, STACK_BOTTOM};

  mem_port_handshake u_mem_port (
    .clock      (clock),
    .reset      (reset),
    .start_c    (hs_start_c),
    .cmd_c      (hs_cmd_c),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (hs_busy),
    .complete_c (hs_complete_c)
  );

  // Next state, operand latching and memory request generation.
  always_comb begin
    state_d    = state_q;
    reg_d      = reg_q;
    sp_d       = sp_q;
    operand_d  = operand_q;
    popped_d   = popped_q;
    hs_start_c = 1'b0;
    hs_cmd_c   = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          reg_d     = cmd_reg;
          sp_d      = sp;
          operand_d = rf_read_data;
          if (limit_fault_c) begin
            state_d = FAULT;
          end else begin
            case (stack_op_t'(cmd_op))
              PUSH:      state_d = PUSH_WR;
              POP:       state_d = POP_RD;
              INT_ENTER: state_d = INT_PC;
              default:   state_d = NOP_DONE;
            endcase
          end
        end
      end
      PUSH_WR: begin
        hs_cmd_c   = '{we: 1'b1, addr: sp_q, wdata: operand_q};
        hs_start_c = !hs_busy;
        if (hs_complete_c) state_d = PUSH_SP;
      end
      POP_RD: begin
        hs_cmd_c   = '{we: 1'b0, addr: sp_q + 16'd1, wdata: '0};
        hs_start_c = !hs_busy;
        if (hs_complete_c) begin
          popped_d = mem_rdata;
          state_d  = POP_WB;
        end
      end
      POP_WB: state_d = (reg_q == REG_SP) ? IDLE : POP_SP;
      INT_PC: begin
        hs_cmd_c   = '{we: 1'b1, addr: sp_q, wdata: pc};
        hs_start_c = !hs_busy;
        if (hs_complete_c) state_d = INT_SR;
      end
      INT_SR: begin
        hs_cmd_c   = '{we: 1'b1, addr: sp_q - 16'd1, wdata: sr};
        hs_start_c = !hs_busy;
        if (hs_complete_c) state_d = INT_SP;
      end
      INT_SP:  state_d = INT_JMP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered by decoding the state about to be entered.
  always_comb begin
    cmd_ready_d     = (state_d == IDLE);
    done_d          = 1'b0;
    fault_d         = 1'b0;
    rf_write_en_d   = 1'b0;
    pc_load_d       = 1'b0;
    sr_load_d       = 1'b0;
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;
    load_data_d     = load_data_q;
    case (state_d)
      PUSH_SP: begin
        rf_write_en_d   = 1'b1;
        rf_write_addr_d = REG_SP;
        rf_write_data_d = sp_d - 16'd1;
        done_d          = 1'b1;
      end
      POP_WB: begin
        if (reg_d == REG_PC) begin
          pc_load_d   = 1'b1;
          load_data_d = popped_d;
        end else if (reg_d == REG_SR) begin
          sr_load_d   = 1'b1;
          load_data_d = popped_d;
        end else begin
          rf_write_en_d   = 1'b1;
          rf_write_addr_d = reg_d;
          rf_write_data_d = popped_d;
          done_d          = (reg_d == REG_SP);
        end
      end
      POP_SP: begin
        rf_write_en_d   = 1'b1;
        rf_write_addr_d = REG_SP;
        rf_write_data_d = sp_d + 16'd1;
        done_d          = 1'b1;
      end
      INT_SP: begin
        rf_write_en_d   = 1'b1;
        rf_write_addr_d = REG_SP;
        rf_write_data_d = sp_d - 16'd2;
      end
      INT_JMP: begin
        pc_load_d   = 1'b1;
        load_data_d = isr;
        done_d      = 1'b1;
      end
      NOP_DONE: done_d  = 1'b1;
      FAULT:    fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      reg_q           <= '0;
      sp_q            <= STACK_TOP;
      operand_q       <= '0;
      popped_q        <= '0;
      cmd_ready_q     <= 1'b1;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      rf_write_en_q   <= 1'b0;
      pc_load_q       <= 1'b0;
      sr_load_q       <= 1'b0;
      load_data_q     <= '0;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      reg_q           <= reg_d;
      sp_q            <= sp_d;
      operand_q       <= operand_d;
      popped_q        <= popped_d;
      cmd_ready_q     <= cmd_ready_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
      rf_write_en_q   <= rf_write_en_d;
      pc_load_q       <= pc_load_d;
      sr_load_q       <= sr_load_d;
      load_data_q     <= load_data_d;
      done_q          <= done_d;
      fault_q         <= fault_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rf_read_addr  = (state_q == IDLE) ? cmd_reg : reg_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_write_en   = rf_write_en_q;
  assign pc_load       = pc_load_q;
  assign sr_load       = sr_load_q;
  assign load_data     = load_data_q;
  assign done          = done_q;

`ifdef STACK_LIMIT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
  logic unused_fault_c;
  assign unused_fault_c = fault_q;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a memory model with programmable wait states and a
// scoreboard of expected memory writes, register writes and PC/SR loads.
module tb_stack_sequencer;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  localparam logic [1:0] K_MEM = 2'd0;
  localparam logic [1:0] K_RF  = 2'd1;
  localparam logic [1:0] K_PC  = 2'd2;
  localparam logic [1:0] K_SR  = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_reg, rf_read_addr, rf_write_addr;
  logic [15:0] rf_read_data, sp, pc, sr, isr, rf_write_data;
  logic        rf_write_en, mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, load_data;
  logic        pc_load, sr_load, done, fault;

  int total = 0;
  int bad = 0;
  int wait_states = 0;
  int wait_cnt = 0;
  int req_len = 0;
  int last_req_len = 0;
  int req_cycles = 0;
  int done_cnt = 0;
  logic [15:0] held_addr;
  logic [15:0] mem_model [logic [15:0]];
  ev_t exp_q [$];

  always #5 clock = ~clock;

  stack_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .sp(sp), .pc(pc), .sr(sr), .isr(isr),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_load(pc_load), .sr_load(sr_load), .load_data(load_data),
    .done(done), .fault(fault)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_observe(input ev_t obs);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_extra: observed=%h expected=none", obs);
    end else begin
      check("sb_event", 34'(obs), 34'(exp_q.pop_front()));
    end
  endtask

  // Memory responder and event monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      req_len   = 0;
    end else begin
      if (done) done_cnt++;
      if (rf_write_en) sb_observe('{kind: K_RF, addr: 16'(rf_write_addr), data: rf_write_data});
      if (pc_load) sb_observe('{kind: K_PC, addr: 16'h0, data: load_data});
      if (sr_load) sb_observe('{kind: K_SR, addr: 16'h0, data: load_data});
      if (mem_req) begin
        req_cycles++;
        if (req_len == 0) held_addr = mem_addr;
        else check("addr_hold", 34'(mem_addr), 34'(held_addr));
        req_len++;
        if (wait_cnt >= wait_states) begin
          mem_ready    = 1'b1;
          wait_cnt     = 0;
          last_req_len = req_len;
          req_len      = 0;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            sb_observe('{kind: K_MEM, addr: mem_addr, data: mem_wdata});
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'hDEAD;
          end
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back('{kind: k, addr: a, data: d});
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] r, input logic [15:0] opnd,
                      input logic [15:0] spv);
    @(negedge clock);
    check("cmd_ready_pre", 34'(cmd_ready), 34'd1);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_reg      = r;
    rf_read_data = opnd;
    sp           = spv;
    #1;
    check("rf_read_addr", 34'(rf_read_addr), 34'(r));
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input logic exp_pc, input logic [15:0] exp_ld);
    int lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (done) begin
        lat = i;
        break;
      end
    end
    check("done_latency", 34'(lat), 34'(exp_lat));
    if (lat != 0) begin
      check("ready_at_done", 34'(cmd_ready), 34'd0);
      check("pc_load_at_done", 34'(pc_load), 34'(exp_pc));
      if (exp_pc) check("load_data_at_done", 34'(load_data), 34'(exp_ld));
      @(negedge clock);
      check("ready_after_done", 34'(cmd_ready), 34'd1);
      check("done_one_cycle", 34'(done), 34'd0);
      check("sb_drained", 34'(exp_q.size()), 34'd0);
    end
  endtask

`ifdef STACK_LIMIT_EN
  task automatic expect_fault(input logic [1:0] op, input logic [15:0] spv);
    int d0 = done_cnt;
    int r0 = req_cycles;
    send(op, 4'h1, 16'h0, spv);
    @(negedge clock);
    check("fault_pulse", 34'(fault), 34'd1);
    check("fault_no_req", 34'(mem_req), 34'd0);
    @(negedge clock);
    check("fault_one_cycle", 34'(fault), 34'd0);
    check("fault_ready", 34'(cmd_ready), 34'd1);
    check("fault_no_done", 34'(done_cnt), 34'(d0));
    check("fault_no_mem", 34'(req_cycles), 34'(r0));
    check("fault_no_events", 34'(exp_q.size()), 34'd0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_reg = 4'h0;
    rf_read_data = 16'h0; sp = 16'hBFFF; pc = 16'h0; sr = 16'h0; isr = 16'h0;
    mem_ready = 1'b0; mem_rdata = 16'h0;
    repeat (2) @(negedge clock);
    check("rst_ready", 34'(cmd_ready), 34'd1);
    check("rst_strobes", 34'({mem_req, mem_we, rf_write_en, pc_load, sr_load, done, fault}), 34'd0);
    check("rst_mem_bus", 34'({mem_addr, mem_wdata}), 34'd0);
    check("rst_rf_bus", 34'({rf_write_addr, rf_write_data}), 34'd0);
    check("rst_load_data", 34'(load_data), 34'd0);
    reset = 1'b1;

    // PUSH r3 with zero-wait memory
    wait_states = 0;
    expect_ev(K_MEM, 16'hBFFF, 16'h1234);
    expect_ev(K_RF, 16'h000D, 16'hBFFE);
    send(2'd0, 4'h3, 16'h1234, 16'hBFFF);
    wait_done(3, 1'b0, 16'h0);

    // POP r5 with two wait states
    mem_model[16'hBFFF] = 16'hBEEF;
    wait_states = 2;
    expect_ev(K_RF, 16'h0005, 16'hBEEF);
    expect_ev(K_RF, 16'h000D, 16'hBFFF);
    send(2'd1, 4'h5, 16'h0, 16'hBFFE);
    wait_done(6, 1'b0, 16'h0);
    check("pop_req_len", 34'(last_req_len), 34'd3);

    // Interrupt entry
    wait_states = 0;
    pc = 16'h0100; sr = 16'h0003; isr = 16'h2000;
    expect_ev(K_MEM, 16'hBFFF, 16'h0100);
    expect_ev(K_MEM, 16'hBFFE, 16'h0003);
    expect_ev(K_RF, 16'h000D, 16'hBFFD);
    expect_ev(K_PC, 16'h0, 16'h2000);
    send(2'd2, 4'h0, 16'h0, 16'hBFFF);
    wait_done(6, 1'b1, 16'h2000);

    // POP into PC
    mem_model[16'hBFFE] = 16'h4321;
    expect_ev(K_PC, 16'h0, 16'h4321);
    expect_ev(K_RF, 16'h000D, 16'hBFFE);
    send(2'd1, 4'hF, 16'h0, 16'hBFFD);
    wait_done(4, 1'b0, 16'h0);

    // POP into SR with one wait state
    wait_states = 1;
    mem_model[16'hBFFE] = 16'h5555;
    expect_ev(K_SR, 16'h0, 16'h5555);
    expect_ev(K_RF, 16'h000D, 16'hBFFE);
    send(2'd1, 4'hE, 16'h0, 16'hBFFD);
    wait_done(5, 1'b0, 16'h0);

    // POP into SP: popped value is the final SP, no increment write
    wait_states = 0;
    mem_model[16'hBFFD] = 16'hA000;
    expect_ev(K_RF, 16'h000D, 16'hA000);
    send(2'd1, 4'hD, 16'h0, 16'hBFFC);
    wait_done(3, 1'b0, 16'h0);

    // Reserved opcode completes as a no-op
    send(2'd3, 4'h0, 16'h0, 16'hBFFF);
    wait_done(1, 1'b0, 16'h0);

`ifdef STACK_LIMIT_EN
    expect_fault(2'd0, 16'h7FFF);
    expect_fault(2'd1, 16'hBFFF);
    expect_fault(2'd2, 16'h8000);
`else
    // SP wraps in both directions
    expect_ev(K_MEM, 16'h0000, 16'h7777);
    expect_ev(K_RF, 16'h000D, 16'hFFFF);
    send(2'd0, 4'h1, 16'h7777, 16'h0000);
    wait_done(3, 1'b0, 16'h0);
    expect_ev(K_RF, 16'h0002, 16'h7777);
    expect_ev(K_RF, 16'h000D, 16'h0000);
    send(2'd1, 4'h2, 16'h0, 16'hFFFF);
    wait_done(4, 1'b0, 16'h0);
`endif

    // Reset during a stalled PUSH write aborts it
    wait_states = 5;
    d0 = done_cnt;
    send(2'd0, 4'h3, 16'hAAAA, 16'hBFFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_req) break;
    end
    check("abort_req_seen", 34'(mem_req), 34'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_req_drop", 34'(mem_req), 34'd0);
    check("abort_ready", 34'(cmd_ready), 34'd1);
    check("abort_done", 34'(done), 34'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_states = 0;
    repeat (4) @(negedge clock);
    check("abort_no_done", 34'(done_cnt), 34'(d0));
    check("abort_ready_after", 34'(cmd_ready), 34'd1);
    check("abort_no_events", 34'(exp_q.size()), 34'd0);

    // Recovery after the abort
    expect_ev(K_MEM, 16'hBFFF, 16'h00C3);
    expect_ev(K_RF, 16'h000D, 16'hBFFE);
    send(2'd0, 4'h6, 16'h00C3, 16'hBFFF);
    wait_done(3, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
